// File: rtl/illm_xpose8.sv
// illm_xpose8 -- 8x8 row-to-column transpose buffer between the row and column
// IDCT passes. Rows of eight 16-bit coefficients arrive one per cycle on eight
// lockstep lanes. Columns leave one per cycle on eight lanes. Both sides use the
// _d/_e/_v/_b stream handshake.
// Build option: define ILLM_XPOSE_PINGPONG_EN for the two-bank (8 cycles/block)
// variant. The default build is a single bank with a FILL/DRAIN/EOSOUT FSM.
module illm_xpose8 (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] r0_d, r1_d, r2_d, r3_d, r4_d, r5_d, r6_d, r7_d,
  input  logic        r0_e, r1_e, r2_e, r3_e, r4_e, r5_e, r6_e, r7_e,
  input  logic        r0_v, r1_v, r2_v, r3_v, r4_v, r5_v, r6_v, r7_v,
  output logic        r0_b, r1_b, r2_b, r3_b, r4_b, r5_b, r6_b, r7_b,
  output logic [15:0] c0_d, c1_d, c2_d, c3_d, c4_d, c5_d, c6_d, c7_d,
  output logic        c0_e, c1_e, c2_e, c3_e, c4_e, c5_e, c6_e, c7_e,
  output logic        c0_v, c1_v, c2_v, c3_v, c4_v, c5_v, c6_v, c7_v,
  input  logic        c0_b, c1_b, c2_b, c3_b, c4_b, c5_b, c6_b, c7_b
);

  logic [7:0][15:0] r_d;
  logic             accept, emit;
  logic             unused_e;

  logic [2:0]       row_cnt_q, row_cnt_d, col_cnt_q, col_cnt_d;
  logic             c_v_q, c_v_d, c_e_q, c_e_d, r_b_q, r_b_d;
  logic [7:0][15:0] c_d_q, c_d_d;
  logic             wr_en;

  // Only lane 0 carries the end-of-stream flag; the other lanes are ignored.
  assign unused_e = ^{r1_e, r2_e, r3_e, r4_e, r5_e, r6_e, r7_e};

  assign r_d    = {r7_d, r6_d, r5_d, r4_d, r3_d, r2_d, r1_d, r0_d};
  assign accept = !r_b_q && (&{r7_v, r6_v, r5_v, r4_v, r3_v, r2_v, r1_v, r0_v});
  assign emit   = c_v_q && !(|{c7_b, c6_b, c5_b, c4_b, c3_b, c2_b, c1_b, c0_b});

  assign {c7_d, c6_d, c5_d, c4_d, c3_d, c2_d, c1_d, c0_d} = c_d_q;
  assign {c7_v, c6_v, c5_v, c4_v, c3_v, c2_v, c1_v, c0_v} = {8{c_v_q}};
  assign {c7_e, c6_e, c5_e, c4_e, c3_e, c2_e, c1_e, c0_e} = {8{c_e_q}};
  assign {r7_b, r6_b, r5_b, r4_b, r3_b, r2_b, r1_b, r0_b} = {8{r_b_q}};

  // Column j of a bank; a row written in this same cycle is bypassed so column 0
  // can be registered on the edge that accepts row 7.
  function automatic logic [7:0][15:0] col_sel(input logic [7:0][7:0][15:0] m,
                                               input logic [2:0] j,
                                               input logic we,
                                               input logic [2:0] wrow,
                                               input logic [7:0][15:0] d);
    logic [7:0][15:0] col;
    for (int k = 0; k < 8; k++)
      col[k] = (we && (wrow == 3'(k))) ? d[j] : m[k][j];
    return col;
  endfunction

  // Registered outputs and counters common to both builds.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      row_cnt_q <= '0;
      col_cnt_q <= '0;
      c_v_q     <= 1'b0;
      c_e_q     <= 1'b0;
      c_d_q     <= '0;
      r_b_q     <= 1'b1;
    end else begin
      row_cnt_q <= row_cnt_d;
      col_cnt_q <= col_cnt_d;
      c_v_q     <= c_v_d;
      c_e_q     <= c_e_d;
      c_d_q     <= c_d_d;
      r_b_q     <= r_b_d;
    end
  end

`ifdef ILLM_XPOSE_PINGPONG_EN
  logic [1:0][7:0][7:0][15:0] mem_q;
  logic [1:0] full_q, full_d;
  logic       fill_bank_q, fill_bank_d, drain_bank_q, drain_bank_d;
  logic       eos_pend_q, eos_pend_d;

  // Bank storage: fill side writes the current row of the fill bank.
  always_ff @(posedge clock) begin
    // NOTE: coefficient storage is deliberately not reset; the full flags
    // decide whether its contents are ever read.
    if (wr_en) mem_q[fill_bank_q][row_cnt_q] <= r_d;
  end

  // Bank control registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      full_q       <= 2'b00;
      fill_bank_q  <= 1'b0;
      drain_bank_q <= 1'b0;
      eos_pend_q   <= 1'b0;
    end else begin
      full_q       <= full_d;
      fill_bank_q  <= fill_bank_d;
      drain_bank_q <= drain_bank_d;
      eos_pend_q   <= eos_pend_d;
    end
  end

  // Independent fill and drain controllers sharing the per-bank full flags.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    row_cnt_d    = row_cnt_q;
    col_cnt_d    = col_cnt_q;
    c_v_d        = c_v_q;
    c_e_d        = c_e_q;
    c_d_d        = c_d_q;
    full_d       = full_q;
    fill_bank_d  = fill_bank_q;
    drain_bank_d = drain_bank_q;
    eos_pend_d   = eos_pend_q;
    wr_en        = 1'b0;
    if (accept) begin
      if (r0_e) begin
        row_cnt_d  = '0;
        eos_pend_d = 1'b1;
      end else begin
        wr_en     = 1'b1;
        row_cnt_d = row_cnt_q + 3'd1;
        if (row_cnt_q == 3'd7) begin
          full_d[fill_bank_q] = 1'b1;
          fill_bank_d         = ~fill_bank_q;
        end
      end
    end
    if (emit) begin
      if (c_e_q) begin
        c_v_d      = 1'b0;
        c_e_d      = 1'b0;
        eos_pend_d = 1'b0;
      end else if (col_cnt_q == 3'd7) begin
        full_d[drain_bank_q] = 1'b0;
        drain_bank_d         = ~drain_bank_q;
        c_v_d                = 1'b0;
        c_d_d                = '0;
      end else begin
        col_cnt_d = col_cnt_q + 3'd1;
        c_d_d = col_sel(mem_q[drain_bank_q], col_cnt_d,
                        wr_en && (fill_bank_q == drain_bank_q), row_cnt_q, r_d);
      end
    end
    // Idle drain side: start the oldest full bank, else a pending EOS once empty.
    if (!c_v_d) begin
      if (full_d[drain_bank_d]) begin
        c_v_d     = 1'b1;
        col_cnt_d = '0;
        c_d_d = col_sel(mem_q[drain_bank_d], 3'd0,
                        wr_en && (fill_bank_q == drain_bank_d), row_cnt_q, r_d);
      end else if (eos_pend_d && (full_d == 2'b00)) begin
        c_v_d = 1'b1;
        c_e_d = 1'b1;
        c_d_d = '0;
      end
    end
    r_b_d = eos_pend_d | full_d[fill_bank_d];
  end
`else
  typedef enum logic [1:0] {FILL, DRAIN, EOSOUT} state_e;

  logic [7:0][7:0][15:0] mem_q;
  state_e                state_q, state_d;

  // Single bank storage written one row per accept.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[row_cnt_q] <= r_d;
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= FILL;
    else       state_q <= state_d;
  end

  // FSM next state, counters and registered output next values.
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    c_v_d     = c_v_q;
    c_e_d     = c_e_q;
    c_d_d     = c_d_q;
    wr_en     = 1'b0;
    unique case (state_q)
      FILL: if (accept) begin
        if (r0_e) begin
          row_cnt_d = '0;
          state_d   = EOSOUT;
          c_v_d     = 1'b1;
          c_e_d     = 1'b1;
          c_d_d     = '0;
        end else begin
          wr_en     = 1'b1;
          row_cnt_d = row_cnt_q + 3'd1;
          if (row_cnt_q == 3'd7) begin
            state_d   = DRAIN;
            col_cnt_d = '0;
            c_v_d     = 1'b1;
            c_e_d     = 1'b0;
            c_d_d     = col_sel(mem_q, 3'd0, 1'b1, row_cnt_q, r_d);
          end
        end
      end
      DRAIN: if (emit) begin
        if (col_cnt_q == 3'd7) begin
          state_d   = FILL;
          row_cnt_d = '0;
          c_v_d     = 1'b0;
          c_d_d     = '0;
        end else begin
          col_cnt_d = col_cnt_q + 3'd1;
          c_d_d     = col_sel(mem_q, col_cnt_d, 1'b0, row_cnt_q, r_d);
        end
      end
      EOSOUT: if (emit) begin
        state_d = FILL;
        c_v_d   = 1'b0;
        c_e_d   = 1'b0;
      end
      default: state_d = FILL;
    endcase
    r_b_d = (state_d != FILL);
  end
`endif

endmodule

// File: tb/tb_illm_xpose8.sv
// tb_illm_xpose8 -- scoreboard bench for illm_xpose8. The stimulus side pushes
// expected column tokens (plain 8x8 transposes and EOS tokens) into a queue;
// a negedge monitor compares and pops whenever the DUT presents a token.
module tb_illm_xpose8;

  typedef struct packed {
    logic             e;
    logic [7:0][15:0] d;
  } tok_t;

  logic             clock = 1'b0;
  logic             reset;
  logic [7:0][15:0] rd;
  logic [7:0]       re, rv;
  logic [7:0]       cb_force, cb_rand;
  wire  [7:0]       c_b;
  wire  [7:0]       r_b, c_e, c_v;
  wire  [7:0][15:0] c_d;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int emit_cnt, first_emit, last_emit, eos_seen, data_seen, rb_stalls;
  bit mon_en, bp_rand;

  tok_t             exp_q[$];
  logic [7:0][15:0] pend_rows[$];

  assign c_b = cb_force | cb_rand;

  always #5 clock = ~clock;

  illm_xpose8 dut (
    .clock(clock), .reset(reset),
    .r0_d(rd[0]), .r1_d(rd[1]), .r2_d(rd[2]), .r3_d(rd[3]),
    .r4_d(rd[4]), .r5_d(rd[5]), .r6_d(rd[6]), .r7_d(rd[7]),
    .r0_e(re[0]), .r1_e(re[1]), .r2_e(re[2]), .r3_e(re[3]),
    .r4_e(re[4]), .r5_e(re[5]), .r6_e(re[6]), .r7_e(re[7]),
    .r0_v(rv[0]), .r1_v(rv[1]), .r2_v(rv[2]), .r3_v(rv[3]),
    .r4_v(rv[4]), .r5_v(rv[5]), .r6_v(rv[6]), .r7_v(rv[7]),
    .r0_b(r_b[0]), .r1_b(r_b[1]), .r2_b(r_b[2]), .r3_b(r_b[3]),
    .r4_b(r_b[4]), .r5_b(r_b[5]), .r6_b(r_b[6]), .r7_b(r_b[7]),
    .c0_d(c_d[0]), .c1_d(c_d[1]), .c2_d(c_d[2]), .c3_d(c_d[3]),
    .c4_d(c_d[4]), .c5_d(c_d[5]), .c6_d(c_d[6]), .c7_d(c_d[7]),
    .c0_e(c_e[0]), .c1_e(c_e[1]), .c2_e(c_e[2]), .c3_e(c_e[3]),
    .c4_e(c_e[4]), .c5_e(c_e[5]), .c6_e(c_e[6]), .c7_e(c_e[7]),
    .c0_v(c_v[0]), .c1_v(c_v[1]), .c2_v(c_v[2]), .c3_v(c_v[3]),
    .c4_v(c_v[4]), .c5_v(c_v[5]), .c6_v(c_v[6]), .c7_v(c_v[7]),
    .c0_b(c_b[0]), .c1_b(c_b[1]), .c2_b(c_b[2]), .c3_b(c_b[3]),
    .c4_b(c_b[4]), .c5_b(c_b[5]), .c6_b(c_b[6]), .c7_b(c_b[7])
  );

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: collect accepted rows; a full block becomes 8 transposed columns.
  task automatic model_accept(input logic [7:0][15:0] d, input logic e);
    tok_t tok;
    if (e) begin
      pend_rows.delete();
      tok.e = 1'b1;
      tok.d = '0;
      exp_q.push_back(tok);
    end else begin
      pend_rows.push_back(d);
      if (pend_rows.size() == 8) begin
        for (int j = 0; j < 8; j++) begin
          tok.e = 1'b0;
          for (int k = 0; k < 8; k++) tok.d[k] = pend_rows[k][j];
          exp_q.push_back(tok);
        end
        pend_rows.delete();
      end
    end
  endtask

  function automatic logic [7:0][15:0] rand_row();
    logic [7:0][15:0] r;
    for (int k = 0; k < 8; k++) r[k] = 16'($urandom);
    return r;
  endfunction

  // Called and returns at posedge+2; drives one row until the DUT accepts it.
  task automatic push_row(input logic [7:0][15:0] d, input logic e, input bit jitter);
    int waits = 0;
    if (jitter && ($urandom_range(0, 3) == 0)) begin
      rd = rand_row();
      re = 8'($urandom);
      rv = 8'($urandom);
      if (rv == 8'hFF) rv = 8'hEF;
      @(posedge clock); #2;
    end
    rd = d;
    re = {7'($urandom), e};
    rv = 8'hFF;
    while (r_b[0] && (waits < 300)) begin
      @(posedge clock); #2;
      waits++;
    end
    if (waits > 0) rb_stalls++;
    if (waits >= 300) begin
      check("row_accept_timeout", 160'(waits), 160'(0));
      rv = 8'h00;
      return;
    end
    model_accept(d, e);
    @(posedge clock); #2;
    rv = 8'h00;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0) && (n < 800)) begin
      @(posedge clock); #2;
      n++;
    end
    check("drain_complete_left", 160'(exp_q.size()), 160'(0));
  endtask

  always @(posedge clock) cyc++;

  // Random consumer back-pressure, applied on any subset of lanes.
  always @(posedge clock) begin
    #2;
    if (bp_rand && ($urandom_range(0, 3) == 0)) cb_rand = 8'($urandom);
    else cb_rand = 8'h00;
  end

  // Monitor: any visible token must match the queue head; pop it when consumed.
  always @(negedge clock) begin
    tok_t tok;
    if (mon_en && (c_v != 8'h00)) begin
      if (exp_q.size() == 0) begin
        check("spurious_token_v", 160'(c_v), 160'(0));
      end else begin
        tok = exp_q[0];
        check("tok_v_lanes", 160'(c_v), 160'(8'hFF));
        check("tok_e_lanes", 160'(c_e), 160'({8{tok.e}}));
        check("tok_d", 160'(c_d), 160'(tok.d));
        if (c_b == 8'h00) begin
          void'(exp_q.pop_front());
          if (tok.e) eos_seen++;
          else data_seen++;
          if (first_emit < 0) first_emit = cyc;
          last_emit = cyc;
          emit_cnt++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0][15:0] row, col0;
    int n, eos0, data0;
    reset = 1'b1; rd = '0; re = '0; rv = '0; cb_force = '0; cb_rand = '0;
    bp_rand = 0; mon_en = 0;
    emit_cnt = 0; first_emit = -1; last_emit = 0; eos_seen = 0; data_seen = 0; rb_stalls = 0;

    // Reset state
    repeat (3) @(posedge clock);
    #2;
    check("rb_during_reset", 160'(r_b), 160'(8'hFF));
    reset = 1'b0;
    @(posedge clock); #2;
    check("rb_after_reset", 160'(r_b), 160'(0));
    check("cv_after_reset", 160'(c_v), 160'(0));
    check("ce_after_reset", 160'(c_e), 160'(0));
    check("cd_after_reset", 160'(c_d), 160'(0));
    mon_en = 1;

    // Identity block and column-0 latency
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 8; k++) row[k] = 16'(16 * i + k);
      push_row(row, 1'b0, 1'b0);
    end
    for (int k = 0; k < 8; k++) col0[k] = 16'(16 * k);
    @(negedge clock);
    check("col0_latency_v", 160'(c_v), 160'(8'hFF));
    check("col0_identity_d", 160'(c_d), 160'(col0));
    @(posedge clock); #2;
    wait_idle();

    // Output stall on lane 3 during column 2
    for (int i = 0; i < 8; i++) push_row(rand_row(), 1'b0, 1'b0);
    @(posedge clock); #2;
    @(posedge clock); #2;
    cb_force = 8'h08;
    repeat (5) @(posedge clock);
    #2;
    cb_force = 8'h00;
    wait_idle();

    // Lockstep input: lane 5 invalid must not consume a row
    for (int i = 0; i < 3; i++) push_row(rand_row(), 1'b0, 1'b0);
    rd = rand_row(); re = 8'h00; rv = 8'hDF;
    repeat (3) begin @(posedge clock); #2; end
    for (int i = 3; i < 7; i++) push_row(rand_row(), 1'b0, 1'b0);
    check("lockstep_no_early_col", 160'(c_v), 160'(0));
    push_row(rand_row(), 1'b0, 1'b0);
    wait_idle();

    // EOS after a partial block, then a full block
    eos0 = eos_seen; data0 = data_seen;
    for (int i = 0; i < 3; i++) push_row(rand_row(), 1'b0, 1'b0);
    push_row(rand_row(), 1'b1, 1'b0);
    wait_idle();
    check("eos_token_count", 160'(eos_seen - eos0), 160'(1));
    check("eos_no_data_cols", 160'(data_seen - data0), 160'(0));
    for (int i = 0; i < 8; i++) push_row(rand_row(), 1'b0, 1'b0);
    wait_idle();

    // Reset in the middle of a drain
    for (int i = 0; i < 8; i++) push_row(rand_row(), 1'b0, 1'b0);
    repeat (4) @(posedge clock);
    #2;
    check("pre_reset_draining", 160'(c_v), 160'(8'hFF));
    reset = 1'b1; mon_en = 0;
    exp_q.delete(); pend_rows.delete();
    @(posedge clock); #2;
    check("reset_mid_cv", 160'(c_v), 160'(0));
    check("reset_mid_rb", 160'(r_b), 160'(8'hFF));
    reset = 1'b0;
    @(posedge clock); #2;
    check("reset_release_rb", 160'(r_b), 160'(0));
    mon_en = 1;
    for (int i = 0; i < 8; i++) push_row(rand_row(), 1'b0, 1'b0);
    wait_idle();

    // Four back-to-back blocks: throughput
    emit_cnt = 0; first_emit = -1; rb_stalls = 0;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 8; i++) push_row(rand_row(), 1'b0, 1'b0);
    wait_idle();
    check("stream_col_count", 160'(emit_cnt), 160'(32));
`ifdef ILLM_XPOSE_PINGPONG_EN
    check("pp_rb_never_asserted", 160'(rb_stalls), 160'(0));
    check("pp_emit_span", 160'(last_emit - first_emit), 160'(31));
`else
    check("sb_emit_span", 160'(last_emit - first_emit), 160'(55));
`endif

    // Randomized blocks, EOS, partial-valid jitter and back-pressure
    bp_rand = 1;
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        n = $urandom_range(0, 7);
        for (int i = 0; i < n; i++) push_row(rand_row(), 1'b0, 1'b1);
        push_row(rand_row(), 1'b1, 1'b1);
      end else begin
        for (int i = 0; i < 8; i++) push_row(rand_row(), 1'b0, 1'b1);
      end
    end
    bp_rand = 0;
    wait_idle();
    repeat (3) @(posedge clock);
    #2;
    check("final_cv_idle", 160'(c_v), 160'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
